iram_stream_loader: RTL

Parametrised instruction memory for the 16-bit minesweeper CPU, and successor to the fixed reset-loaded instruction ROM. The program image is no longer hard-coded. After reset, or on request, the block zero-fills itself, then accepts an image over a valid/ready stream. Only then does it serve byte-addressed instruction fetches, with a registered read and a valid flag. It sits between the CPU fetch stage and the board-side program loader (UART/host bridge).

---
 rtl/iram_stream_loader.sv | 129 ++++++++++++
 1 files changed

// File: rtl/iram_stream_loader.sv
// Instruction RAM with zero-fill, stream image loader and registered byte-addressed fetch.
// Define IRAM_PARITY_EN to store a per-word even-parity bit and report PERR on fetch.
module iram_stream_loader #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 512,
  parameter int ADDR_W = 10
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [ADDR_W-1:0]        ADDR,
  output logic [DATA_W-1:0]        Q,
  output logic                     Q_VALID,
  output logic                     ALIGN_ERR,
  output logic                     BUSY,
  input  logic                     LD_START,
  input  logic                     LD_VALID,
  output logic                     LD_READY,
  input  logic [DATA_W-1:0]        LD_DATA,
  input  logic                     LD_LAST,
  output logic [$clog2(DEPTH):0]   LD_COUNT,
  output logic                     PERR
);

  localparam int OFF   = $clog2(DATA_W / 8);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int IDX_W = ADDR_W - OFF;

  localparam logic [1:0] S_CLEAR = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;

  logic [1:0]        state;
  logic [PTR_W-1:0]  ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [IDX_W-1:0]  idx;
  logic [PTR_W-1:0]  rd_idx;
  logic              in_range;
  logic              last_ptr;
  logic              xfer;
  logic              we;
  logic [DATA_W-1:0] wdata;
  logic              fetch;

  assign idx      = ADDR[ADDR_W-1:OFF];
  assign rd_idx   = idx[PTR_W-1:0];
  // one extra bit so DEPTH itself is representable when IDX_W == PTR_W
  assign in_range = ({1'b0, idx} < (IDX_W + 1)'(DEPTH));
  assign last_ptr = (ptr == PTR_W'(DEPTH - 1));
  assign xfer     = (state == S_LOAD) && LD_VALID;
  assign we       = (state == S_CLEAR) || xfer;
  assign wdata    = (state == S_CLEAR) ? '0 : LD_DATA;
  assign fetch    = (state == S_RUN) && !LD_START;

  assign BUSY     = (state != S_RUN);
  assign LD_READY = (state == S_LOAD);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= S_CLEAR;
      ptr      <= '0;
      LD_COUNT <= '0;
    end else begin
      case (state)
        S_CLEAR: begin
          ptr <= last_ptr ? '0 : ptr + PTR_W'(1);
          if (last_ptr) state <= S_LOAD;
        end
        S_LOAD: begin
          if (LD_VALID) begin
            LD_COUNT <= LD_COUNT + ($clog2(DEPTH) + 1)'(1);
            if (LD_LAST || last_ptr) begin
              state <= S_RUN;
              ptr   <= '0;
            end else begin
              ptr <= ptr + PTR_W'(1);
            end
          end
        end
        S_RUN: begin
          if (LD_START) begin
            state    <= S_CLEAR;
            ptr      <= '0;
            LD_COUNT <= '0;
          end
        end
        default: state <= S_CLEAR;
      endcase
    end
  end

  // fetch pipeline; a reload request on the fetch cycle drops that fetch
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      Q         <= '0;
      Q_VALID   <= 1'b0;
      ALIGN_ERR <= 1'b0;
    end else if (fetch) begin
      Q         <= in_range ? mem[rd_idx] : '0;
      Q_VALID   <= 1'b1;
      ALIGN_ERR <= |ADDR[OFF-1:0];
    end else begin
      Q         <= '0;
      Q_VALID   <= 1'b0;
      ALIGN_ERR <= 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (we) mem[ptr] <= wdata;
  end

`ifdef IRAM_PARITY_EN
  logic par [DEPTH];

  always_ff @(posedge CLK) begin
    if (we) par[ptr] <= ^wdata;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)                     PERR <= 1'b0;
    else if (fetch && in_range)    PERR <= (^mem[rd_idx]) ^ par[rd_idx];
    else                           PERR <= 1'b0;
  end
`else
  assign PERR = 1'b0;
`endif

endmodule
